// File: rtl/preempt_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | preempt_scheduler: lamp-driver front end that preempts the normal phase     |
// | cycle for emergency (round-robin) and pedestrian requests.                  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module preempt_scheduler #(
  parameter int YELLOW_T  = 3,
  parameter int CLEAR_T   = 2,
  parameter int GRANT_MAX = 20,
  parameter int PED_T     = 10
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic [3:0] emg_req,
  input  logic       ped_req,
  input  logic [2:0] nrm_A,
  input  logic [2:0] nrm_B,
  input  logic [2:0] nrm_C,
  input  logic [2:0] nrm_D,
  output logic [2:0] st_A,
  output logic [2:0] st_B,
  output logic [2:0] st_C,
  output logic [2:0] st_D,
  output logic       hold,
  output logic [3:0] grant,
  output logic       ped_walk
);

  localparam logic [2:0] S_NORMAL = 3'd0;
  localparam logic [2:0] S_YELLOW = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_GRANT  = 3'd3;
  localparam logic [2:0] S_EXIT_Y = 3'd4;
  localparam logic [2:0] S_PED    = 3'd5;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  localparam logic [7:0] YEL_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] CLR_LAST = 8'(CLEAR_T - 1);
  localparam logic [7:0] GNT_LAST = 8'(GRANT_MAX - 1);
  localparam logic [7:0] PED_LAST = 8'(PED_T - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] win_q, win_d;
  logic       pend_q, pend_d;
  logic [3:0] snap_q, snap_d;

  logic [2:0] nrm [4];
  logic [2:0] lamp [4];
  logic [3:0] nrm_green;
  logic [1:0] arb_win;
  logic [1:0] arb_idx;
  logic       arb_hit;

  assign nrm[0] = nrm_A;
  assign nrm[1] = nrm_B;
  assign nrm[2] = nrm_C;
  assign nrm[3] = nrm_D;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_green
      assign nrm_green[g] = (nrm[g] == LAMP_G);
    end
  endgenerate

  // Rotating priority: first requester at or after ptr_q wins.
  always_comb begin
    arb_win = 2'd0;
    arb_idx = 2'd0;
    arb_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      arb_idx = ptr_q + 2'(i);
      if (!arb_hit && emg_req[arb_idx]) begin
        arb_win = arb_idx;
        arb_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1Hz or negedge reset) begin
    if (!reset) begin
      state_q <= S_CLEAR;
      tmr_q   <= 8'd0;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      pend_q  <= 1'b0;
      snap_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q == 8'hFF) ? tmr_q : tmr_q + 8'd1;
    ptr_d   = ptr_q;
    win_d   = win_q;
    snap_d  = snap_q;
    pend_d  = pend_q | ped_req;
    case (state_q)
      S_NORMAL: begin
        if ((|emg_req) || pend_q) begin
          snap_d  = nrm_green;
          state_d = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (tmr_q == YEL_LAST) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (tmr_q == CLR_LAST) begin
          if (|emg_req) begin
            state_d = S_GRANT;
            win_d   = arb_win;
            ptr_d   = arb_win + 2'd1;
          end else if (pend_q) begin
            // A button press on this same edge is absorbed by the walk.
            state_d = S_PED;
            pend_d  = 1'b0;
          end else begin
            state_d = S_NORMAL;
          end
        end
      end
      S_GRANT: begin
        if (!emg_req[win_q] || (tmr_q == GNT_LAST)) state_d = S_EXIT_Y;
      end
      S_EXIT_Y: begin
        if (tmr_q == YEL_LAST) state_d = S_CLEAR;
      end
      S_PED: begin
        if ((|emg_req) || (tmr_q == PED_LAST)) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
    if (state_d != state_q) tmr_d = 8'd0;
  end

  always_comb begin
    hold     = 1'b1;
    grant    = 4'd0;
    ped_walk = 1'b0;
    for (int i = 0; i < 4; i++) lamp[i] = LAMP_R;
    case (state_q)
      S_NORMAL: begin
        hold = 1'b0;
        for (int i = 0; i < 4; i++) lamp[i] = nrm[i];
      end
      S_YELLOW: begin
        for (int i = 0; i < 4; i++) if (snap_q[i]) lamp[i] = LAMP_Y;
      end
      S_GRANT: begin
        lamp[win_q]  = LAMP_G;
        grant[win_q] = 1'b1;
      end
      S_EXIT_Y: lamp[win_q] = LAMP_Y;
      S_PED:    ped_walk = 1'b1;
      default:  ;
    endcase
  end

  assign st_A = lamp[0];
  assign st_B = lamp[1];
  assign st_C = lamp[2];
  assign st_D = lamp[3];

endmodule
`default_nettype wire

// File: tb/tb_preempt_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_preempt_scheduler: directed table, corner sequences and random stimulus  |
// | against a phase/countdown reference model.   Revision: 1.0                  |
// +----------------------------------------------------------------------------+
module tb_preempt_scheduler;

  localparam int YELLOW_T  = 3;
  localparam int CLEAR_T   = 2;
  localparam int GRANT_MAX = 20;
  localparam int PED_T     = 10;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  localparam int P_NRM = 0, P_YEL = 1, P_CLR = 2, P_GNT = 3, P_EXY = 4, P_PED = 5;

  logic        clk_1Hz = 1'b0;
  logic        reset;
  logic [3:0]  emg_req = 4'd0;
  logic        ped_req = 1'b0;
  logic [11:0] nrm = 12'd0;
  logic [2:0]  st_A, st_B, st_C, st_D;
  logic        hold, ped_walk;
  logic [3:0]  grant;
  logic [17:0] dout;

  int checks = 0;
  int failures = 0;

  // Reference model: current phase, cycles left in it, rotating pointer.
  int       m_ph, m_left, m_ptr, m_win;
  bit       m_pend;
  bit [3:0] m_snap;

  always #5 clk_1Hz = ~clk_1Hz;

  preempt_scheduler #(
    .YELLOW_T(YELLOW_T), .CLEAR_T(CLEAR_T), .GRANT_MAX(GRANT_MAX), .PED_T(PED_T)
  ) dut (
    .clk_1Hz(clk_1Hz), .reset(reset), .emg_req(emg_req), .ped_req(ped_req),
    .nrm_A(nrm[11:9]), .nrm_B(nrm[8:6]), .nrm_C(nrm[5:3]), .nrm_D(nrm[2:0]),
    .st_A(st_A), .st_B(st_B), .st_C(st_C), .st_D(st_D),
    .hold(hold), .grant(grant), .ped_walk(ped_walk)
  );

  assign dout = {st_A, st_B, st_C, st_D, hold, grant, ped_walk};

  function automatic logic [17:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] c, input logic [2:0] d,
                                     input logic h, input logic [3:0] g, input logic w);
    return {a, b, c, d, h, g, w};
  endfunction

  function automatic logic [2:0] lamp_of(input int i, input logic [11:0] n);
    return n[11-3*i -: 3];
  endfunction

  task automatic mreset();
    m_ph = P_CLR; m_left = CLEAR_T; m_ptr = 0; m_win = 0; m_pend = 0; m_snap = 4'd0;
  endtask

  task automatic go(input int ph, input int len);
    m_ph = ph; m_left = len;
  endtask

  task automatic mstep();
    bit into_ped = 0;
    bit pend_in  = m_pend | ped_req;
    bit found    = 0;
    case (m_ph)
      P_NRM: if (emg_req != 0 || m_pend) begin
        for (int i = 0; i < 4; i++) m_snap[i] = (lamp_of(i, nrm) == G);
        go(P_YEL, YELLOW_T);
      end
      P_YEL: begin m_left--; if (m_left == 0) go(P_CLR, CLEAR_T); end
      P_CLR: begin
        m_left--;
        if (m_left == 0) begin
          if (emg_req != 0) begin
            for (int k = 0; k < 4; k++)
              if (!found && emg_req[(m_ptr + k) % 4]) begin m_win = (m_ptr + k) % 4; found = 1; end
            m_ptr = (m_win + 1) % 4;
            go(P_GNT, GRANT_MAX);
          end else if (m_pend) begin
            go(P_PED, PED_T);
            into_ped = 1;
          end else go(P_NRM, 0);
        end
      end
      P_GNT: begin m_left--; if (!emg_req[m_win] || m_left == 0) go(P_EXY, YELLOW_T); end
      P_EXY: begin m_left--; if (m_left == 0) go(P_CLR, CLEAR_T); end
      default: begin m_left--; if (emg_req != 0 || m_left == 0) go(P_CLR, CLEAR_T); end
    endcase
    m_pend = into_ped ? 1'b0 : pend_in;
  endtask

  function automatic logic [17:0] mexp();
    logic [2:0] l [4];
    logic h = 1'b1;
    logic [3:0] g = 4'd0;
    logic w = 1'b0;
    for (int i = 0; i < 4; i++) l[i] = R;
    case (m_ph)
      P_NRM: begin h = 1'b0; for (int i = 0; i < 4; i++) l[i] = lamp_of(i, nrm); end
      P_YEL: for (int i = 0; i < 4; i++) if (m_snap[i]) l[i] = Y;
      P_GNT: begin l[m_win] = G; g[m_win] = 1'b1; end
      P_EXY: l[m_win] = Y;
      P_PED: w = 1'b1;
      default: ;
    endcase
    return {l[0], l[1], l[2], l[3], h, g, w};
  endfunction

  task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (stA,B,C,D,hold,grant,walk) t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model", dout, mexp());
  endtask

  // One clock: model consumes the inputs sampled at the edge, then new inputs are driven.
  task automatic cyc(input logic [3:0] e, input logic p, input logic [11:0] n);
    @(posedge clk_1Hz);
    if (!reset) mreset(); else mstep();
    #1;
    emg_req = e; ped_req = p; nrm = n;
    #1;
    chk_model();
  endtask

  task automatic rel_reset(input logic [3:0] e);
    @(posedge clk_1Hz);
    mreset();
    #1;
    reset = 1'b1; emg_req = e; ped_req = 1'b0;
    #1;
    chk_model();
  endtask

  task automatic assert_reset(input logic [3:0] e);
    #1;
    reset = 1'b0; emg_req = e;
    mreset();
    #1;
    chk_model();
  endtask

  task automatic wait_for(input logic [3:0] e, input logic [17:0] v, input int maxc, input string nm);
    int b = 0;
    while (dout !== v && b < maxc) begin cyc(e, 1'b0, nrm); b++; end
    chk(nm, dout, v);
  endtask

  task automatic run_len(input logic [3:0] e, input logic [17:0] v, output int len);
    len = 0;
    while (dout === v && len < 200) begin cyc(e, 1'b0, nrm); len++; end
  endtask

  typedef struct {
    logic [3:0]  emg;
    logic        ped;
    int          n;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [11:0] NRM0;
    logic [17:0] RED, NORMV, YAC, GC, YC, WALK, GA, YA, GB, GD;
    logic [17:0] rr [4];
    logic [3:0]  e;
    int len;

    NRM0  = {G, R, G, R};
    RED   = mk(R, R, R, R, 1'b1, 4'b0000, 1'b0);
    NORMV = mk(G, R, G, R, 1'b0, 4'b0000, 1'b0);
    YAC   = mk(Y, R, Y, R, 1'b1, 4'b0000, 1'b0);
    GC    = mk(R, R, G, R, 1'b1, 4'b0100, 1'b0);
    YC    = mk(R, R, Y, R, 1'b1, 4'b0000, 1'b0);
    WALK  = mk(R, R, R, R, 1'b1, 4'b0000, 1'b1);
    GA    = mk(G, R, R, R, 1'b1, 4'b0001, 1'b0);
    YA    = mk(Y, R, R, R, 1'b1, 4'b0000, 1'b0);
    GB    = mk(R, G, R, R, 1'b1, 4'b0010, 1'b0);
    GD    = mk(R, R, R, G, 1'b1, 4'b1000, 1'b0);

    tbl[0]  = '{4'b0000, 1'b0,  1, RED};
    tbl[1]  = '{4'b0000, 1'b0,  2, NORMV};
    tbl[2]  = '{4'b0100, 1'b0,  1, NORMV};
    tbl[3]  = '{4'b0100, 1'b0,  3, YAC};
    tbl[4]  = '{4'b0100, 1'b0,  2, RED};
    tbl[5]  = '{4'b0100, 1'b0,  4, GC};
    tbl[6]  = '{4'b0000, 1'b0,  1, GC};
    tbl[7]  = '{4'b0000, 1'b0,  3, YC};
    tbl[8]  = '{4'b0000, 1'b0,  2, RED};
    tbl[9]  = '{4'b0000, 1'b0,  2, NORMV};
    tbl[10] = '{4'b0000, 1'b1,  1, NORMV};
    tbl[11] = '{4'b0000, 1'b0,  1, NORMV};
    tbl[12] = '{4'b0000, 1'b0,  3, YAC};
    tbl[13] = '{4'b0000, 1'b0,  2, RED};
    tbl[14] = '{4'b0000, 1'b0, 10, WALK};
    tbl[15] = '{4'b0000, 1'b0,  2, RED};
    tbl[16] = '{4'b0000, 1'b0,  3, NORMV};

    reset = 1'b1;
    nrm = NRM0;
    #1;
    reset = 1'b0;
    mreset();
    #1;
    chk("reset_state", dout, RED);
    repeat (2) @(posedge clk_1Hz);
    rel_reset(4'b0000);
    chk("reset_release", dout, RED);

    for (int r = 0; r < 17; r++)
      for (int k = 0; k < tbl[r].n; k++) begin
        cyc(tbl[r].emg, tbl[r].ped, NRM0);
        chk($sformatf("tbl%0d_%0d", r, k), dout, tbl[r].exp);
      end

    // Lone requester held past timeout.
    wait_for(4'b0001, GA, 30, "t3_first_grant");
    run_len(4'b0001, GA, len);
    chk_int("t3_grant_len", len, GRANT_MAX);
    run_len(4'b0001, YA, len);
    chk_int("t3_exit_len", len, YELLOW_T);
    run_len(4'b0001, RED, len);
    chk_int("t3_clear_len", len, CLEAR_T);
    chk("t3_regrant", dout, GA);
    wait_for(4'b0000, NORMV, 40, "t3_back_normal");

    // Round-robin among A, B, D from reset.
    assert_reset(4'b1011);
    rel_reset(4'b1011);
    rr[0] = GA; rr[1] = GB; rr[2] = GD; rr[3] = GA;
    for (int i = 0; i < 4; i++) begin
      wait_for(4'b1011, rr[i], 40, $sformatf("t4_grant%0d", i));
      run_len(4'b1011, rr[i], len);
      chk_int($sformatf("t4_len%0d", i), len, GRANT_MAX);
    end
    wait_for(4'b0000, NORMV, 40, "t4_back_normal");

    // Emergency aborts a walk, then reset in the resulting grant.
    cyc(4'b0000, 1'b1, NRM0);
    wait_for(4'b0000, WALK, 20, "t6_walk_start");
    cyc(4'b0000, 1'b0, NRM0);
    cyc(4'b0000, 1'b0, NRM0);
    chk("t6_walk3", dout, WALK);
    cyc(4'b0010, 1'b0, NRM0);
    chk("t6_walk4", dout, WALK);
    cyc(4'b0010, 1'b0, NRM0);
    chk("t6_abort", dout, RED);
    cyc(4'b0010, 1'b0, NRM0);
    chk("t6_clear2", dout, RED);
    cyc(4'b0010, 1'b0, NRM0);
    chk("t6_grantB", dout, GB);
    assert_reset(4'b0010);
    chk("t6_reset_red", dout, RED);
    rel_reset(4'b0000);
    cyc(4'b0000, 1'b0, NRM0);
    cyc(4'b0000, 1'b0, NRM0);
    chk("t6_normal", dout, NORMV);

    // Random traffic, button presses, controller codes and async resets.
    e = 4'd0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0)
        e = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      if (!reset) begin
        if ($urandom_range(0, 2) == 0) rel_reset(e);
        else cyc(e, 1'b0, 12'($urandom));
      end else begin
        cyc(e, ($urandom_range(0, 15) == 0), 12'($urandom));
        if ($urandom_range(0, 399) == 0) assert_reset(e);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
